fp_mac_feeder: RTL and testbench

FP_MAC_FEEDER -- requirements
Module: fp_mac_feeder

---
 rtl/fp_mac_feeder.sv | 148 ++++++++++++++
 tb/tb_fp_mac_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mac_feeder.sv
// Operand FIFO and burst sequencer feeding an fp_mac: K back-to-back beats per burst,
// then a drain window that waits for the accumulator result or times out.
//
// state | meaning
// IDLE  | waiting for at least K queued operand pairs
// BURST | popping one pair per cycle onto m_win/m_din
// DRAIN | m_vld low; waiting for mac_vld_i (min GAP cycles) or TIMEOUT
module fp_mac_feeder #(
  parameter int WIDTH   = 8,
  parameter int K       = 1,
  parameter int DEPTH   = 16,
  parameter int GAP     = 11,
  parameter int TIMEOUT = 63
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             s_vld,
  output logic             s_rdy,
  input  logic [WIDTH-1:0] s_win,
  input  logic [WIDTH-1:0] s_din,
  output logic             m_vld,
  output logic [WIDTH-1:0] m_win,
  output logic [WIDTH-1:0] m_din,
  input  logic             mac_vld_i,
  input  logic [WIDTH-1:0] mac_acc_i,
  output logic [WIDTH-1:0] res_o,
  output logic             res_vld_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = (K > 1) ? $clog2(K) : 1;
  localparam int DW = $clog2(TIMEOUT) + 1;

  localparam logic [CW-1:0] K_CNT     = CW'(K);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(K - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(GAP - 1);
  localparam logic [DW-1:0] TO_LAST   = DW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [BW-1:0]        beat_cnt;
  logic [DW-1:0]        drain_cnt;
  logic                 seen;
  logic                 wr;
  logic                 start;
  logic                 pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Fullness is judged on the registered count only, so a pop never frees a slot in the same cycle.
  assign s_rdy  = (count < FULL);
  assign wr     = s_vld && s_rdy;
  assign start  = (state == S_IDLE) && (count >= K_CNT);
  assign pop    = start || (state == S_BURST);
  assign busy_o = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_ptr] <= {s_win, s_din};
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= ptr_next(wr_ptr);
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state     <= S_IDLE;
      m_vld     <= 1'b0;
      m_win     <= '0;
      m_din     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      seen      <= 1'b0;
      res_o     <= '0;
      res_vld_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      res_vld_o <= mac_vld_i;
      if (mac_vld_i) res_o <= mac_acc_i;
      err_o <= 1'b0;
      if (pop) {m_win, m_din} <= mem[rd_ptr];

      case (state)
        S_IDLE: begin
          m_vld <= 1'b0;
          if (start) begin
            m_vld     <= 1'b1;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            seen      <= 1'b0;
            // A single-beat burst is complete on the entry edge.
            state     <= (K == 1) ? S_DRAIN : S_BURST;
          end
        end
        S_BURST: begin
          m_vld    <= 1'b1;
          beat_cnt <= beat_cnt + BW'(1);
          if (beat_cnt + BW'(1) == LAST_BEAT) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
            seen      <= 1'b0;
          end
        end
        S_DRAIN: begin
          m_vld <= 1'b0;
          if (mac_vld_i) seen <= 1'b1;
          if (drain_cnt >= GAP_LAST && (seen || mac_vld_i)) begin
            state <= S_IDLE;
          end else if (drain_cnt == TO_LAST) begin
            state <= S_IDLE;
            err_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          m_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mac_feeder.sv
// Scoreboard bench for fp_mac_feeder: accepted pairs are queued at the handshake and
// a burst/drain phase model checks beats, spacing, results and timeouts every cycle.
module tb_fp_mac_feeder;
  localparam int WIDTH   = 8;
  localparam int K       = 4;
  localparam int DEPTH   = 8;
  localparam int GAP     = 11;
  localparam int TIMEOUT = 32;

  logic             clk_i = 1'b0;
  logic             rst;
  logic             s_vld;
  logic             s_rdy;
  logic [WIDTH-1:0] s_win;
  logic [WIDTH-1:0] s_din;
  logic             m_vld;
  logic [WIDTH-1:0] m_win;
  logic [WIDTH-1:0] m_din;
  logic             mac_vld_i;
  logic [WIDTH-1:0] mac_acc_i;
  logic [WIDTH-1:0] res_o;
  logic             res_vld_o;
  logic             err_o;
  logic             busy_o;

  always #5 clk_i = ~clk_i;

  fp_mac_feeder #(.WIDTH(WIDTH), .K(K), .DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy), .s_win(s_win), .s_din(s_din),
    .m_vld(m_vld), .m_win(m_win), .m_din(m_din), .mac_vld_i(mac_vld_i), .mac_acc_i(mac_acc_i),
    .res_o(res_o), .res_vld_o(res_vld_o), .err_o(err_o), .busy_o(busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: flow-level phases derived from the burst/drain rules.
  typedef enum int {P_IDLE, P_BURST, P_DRAIN} ph_t;
  ph_t              ph = P_IDLE;
  logic [15:0]      exp_q[$];
  int               occ = 0;
  int               beats_left = 0;
  int               beats_total = 0;
  int               m_cyc = 0;
  bit               m_seen = 0;
  bit               err_exp = 0;
  bit               rst_q = 1;
  bit               res_pend = 0;
  logic [WIDTH-1:0] res_exp = '0;
  logic [WIDTH-1:0] res_model = '0;

  always @(posedge clk_i) begin
    rst_q = rst;
    if (rst) begin
      exp_q.delete();
      occ = 0;
      ph = P_IDLE;
      res_pend = 0;
      res_model = '0;
      err_exp = 0;
    end else begin
      if (s_vld && s_rdy) begin
        exp_q.push_back({s_win, s_din});
        occ++;
      end
      res_pend = mac_vld_i;
      if (mac_vld_i) res_exp = mac_acc_i;
    end
  end

  task automatic drain_step();
    if (mac_vld_i) m_seen = 1;
    if (m_cyc >= GAP - 1 && m_seen) ph = P_IDLE;
    else if (m_cyc == TIMEOUT - 1) begin
      ph = P_IDLE;
      err_exp = 1;
    end
  endtask

  always @(negedge clk_i) begin
    bit was_idle;
    logic [15:0] pair;
    if (rst_q) begin
      chk("rst_m_vld", m_vld, 0);
      chk("rst_m_data", {m_win, m_din}, 0);
      chk("rst_res_o", res_o, 0);
      chk("rst_res_vld", res_vld_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_s_rdy", s_rdy, 1);
    end else begin
      was_idle = (ph == P_IDLE);
      chk("busy_o", busy_o, ph != P_IDLE);
      chk("err_o", err_o, err_exp);
      err_exp = 0;
      chk("res_vld_o", res_vld_o, res_pend);
      if (res_pend) res_model = res_exp;
      chk("res_o", res_o, res_model);
      case (ph)
        P_IDLE: chk("m_vld_idle", m_vld, 0);
        P_BURST: begin
          chk("m_vld_burst", m_vld, 1);
          if (m_vld) begin
            occ--;
            beats_total++;
            if (exp_q.size() == 0) fail_now("beat_without_data");
            else begin
              pair = exp_q.pop_front();
              chk("m_data", {m_win, m_din}, pair);
            end
          end
          beats_left--;
          if (beats_left == 0) begin
            ph = P_DRAIN;
            m_cyc = 0;
            m_seen = 0;
            drain_step();
          end
        end
        P_DRAIN: begin
          chk("m_vld_drain", m_vld, 0);
          m_cyc++;
          drain_step();
        end
        default: ;
      endcase
      chk("s_rdy", s_rdy, occ < DEPTH);
      if (was_idle && occ >= K) begin
        ph = P_BURST;
        beats_left = K;
      end
    end
  end

  // Stimulus
  bit auto_mac = 0;

  task automatic cyc();
    @(posedge clk_i);
    #1;
    if (auto_mac) begin
      mac_vld_i = ($urandom_range(0, 7) == 0);
      mac_acc_i = WIDTH'($urandom);
    end
  endtask

  task automatic put(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] d);
    bit acc;
    int n;
    n = 0;
    s_vld = 1;
    s_win = w;
    s_din = d;
    forever begin
      acc = s_rdy;
      cyc();
      n++;
      if (acc) break;
      if (n > 200) begin
        fail_now("put_wait");
        break;
      end
    end
    s_vld = 0;
  endtask

  task automatic wait_drain_cyc(input int c);
    int n;
    n = 0;
    while (!(ph == P_DRAIN && m_cyc == c) && n < 300) begin
      cyc();
      n++;
    end
    if (n >= 300) fail_now("wait_drain");
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (!(ph == P_IDLE && occ < K) && n < 800) begin
      cyc();
      n++;
    end
    if (n >= 800) fail_now("settle");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int n;
    rst = 1;
    s_vld = 0;
    s_win = '0;
    s_din = '0;
    mac_vld_i = 0;
    mac_acc_i = '0;
    repeat (3) cyc();
    rst = 0;
    cyc();

    // Directed burst, then a result part-way through the drain window.
    for (int i = 0; i < 4; i++) put(WIDTH'(8'h11 + i), WIDTH'(8'h21 + i));
    wait_drain_cyc(8);
    mac_vld_i = 1;
    mac_acc_i = 8'h3C;
    cyc();
    mac_vld_i = 0;
    mac_acc_i = '0;
    chk("res_3c", res_o, 8'h3C);
    chk("res_3c_vld", res_vld_o, 1);
    cyc();
    chk("res_3c_pulse", res_vld_o, 0);
    settle();

    // Timeout drain, filling the FIFO while nothing pops.
    for (int i = 0; i < 4; i++) put(WIDTH'($urandom), WIDTH'($urandom));
    wait_drain_cyc(0);
    for (int i = 0; i < 8; i++) put(WIDTH'($urandom), WIDTH'($urandom));
    chk("full_after_8", s_rdy, 0);
    s_vld = 1;
    s_win = 8'hEE;
    s_din = 8'hEE;
    cyc();
    s_vld = 0;
    chk("ninth_refused", s_rdy, 0);
    settle();

    // Continuous offer with overlapping writes and pops.
    auto_mac = 1;
    for (int i = 0; i < 12; i++) put(WIDTH'($urandom), WIDTH'($urandom));
    settle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s_vld = $urandom_range(0, 1) == 1;
      s_win = WIDTH'($urandom);
      s_din = WIDTH'($urandom);
      cyc();
    end
    s_vld = 0;
    settle();

    // Reset during the second beat of a burst.
    auto_mac = 0;
    mac_vld_i = 0;
    cyc();
    b0 = beats_total;
    for (int i = 0; i < 6; i++) put(WIDTH'($urandom), WIDTH'($urandom));
    n = 0;
    while (beats_total < b0 + 1 && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) fail_now("wait_first_beat");
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_mid_m_vld", m_vld, 0);
    chk("rst_mid_s_rdy", s_rdy, 1);
    repeat (20) cyc();
    auto_mac = 1;
    for (int i = 0; i < 4; i++) put(WIDTH'($urandom), WIDTH'($urandom));
    settle();
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
